// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stage boundary indices within the stall vector.
package pipe_ctrl_pkg;

    localparam int STALL_PC    = 0;
    localparam int STALL_IFID  = 1;
    localparam int STALL_ID    = 2;
    localparam int STALL_IDEX  = 3;
    localparam int STALL_EXMEM = 4;

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// Event counter with enable; optionally saturates at all-ones instead of wrapping.
// Latency: count visible the cycle after the enabled edge.
// Backpressure: none, counts every enabled cycle.
module pipe_ctrl_perf_cnt #(
    parameter int W   = 32,
    parameter bit SAT = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en && !(SAT && (&cnt))) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush control with held-jump and stale-fetch drain sequencing.
// Latency: stall, flush and redirect outputs are combinational from this cycle's requests.
// Backpressure: a jump arriving while EX is frozen is held until the freeze lifts.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_W = 6,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_stall_req,
    input  logic               if_fetch_done,
    input  logic               id_stall_req,
    input  logic               mem_stall_req,
    input  logic               ex_jump_req,
    input  logic [ADDR_W-1:0]  ex_jump_addr,
    output logic [STALL_W-1:0] stall_state,
    output logic               jump_flag,
    output logic               pc_redirect,
    output logic [ADDR_W-1:0]  redirect_addr,
    output logic               drop_fetch,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [CNT_W-1:0]   flush_count
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HOLD_JUMP = 2'd1,
        DRAIN     = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pend_addr, pend_addr_nxt;
    logic [STALL_W-1:0]  stall_req;
    logic                frozen;

    // MEM/WB bit is never set: a MEM stall lets MEM/WB take a bubble.
    always_comb begin
        stall_req = '0;
        if (mem_stall_req) begin
            stall_req[STALL_EXMEM:STALL_PC] = '1;
        end else if (id_stall_req) begin
            stall_req[STALL_ID:STALL_PC] = '1;
        end else if (if_stall_req) begin
            stall_req[STALL_IFID:STALL_PC] = '1;
        end
    end

    assign frozen = stall_req[STALL_IDEX];

    always_comb begin
        state_nxt     = state;
        pend_addr_nxt = pend_addr;
        pc_redirect   = 1'b0;
        redirect_addr = '0;
        drop_fetch    = 1'b0;
        stall_state   = stall_req;

        unique case (state)
            RUN: begin
                if (ex_jump_req) begin
                    if (!frozen) begin
                        pc_redirect   = 1'b1;
                        redirect_addr = ex_jump_addr;
                    end else begin
                        pend_addr_nxt = ex_jump_addr;
                        state_nxt     = HOLD_JUMP;
                    end
                end
            end
            HOLD_JUMP: begin
                if (!frozen) begin
                    pc_redirect   = 1'b1;
                    redirect_addr = pend_addr;
                end
            end
            DRAIN: begin
                drop_fetch             = 1'b1;
                stall_state[STALL_PC]  = 1'b1;
                if (if_fetch_done) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase

        // A fetch returning in the redirect cycle is the stale word: drop it now, no drain needed.
        if (pc_redirect) begin
            if (if_fetch_done) begin
                drop_fetch = 1'b1;
                state_nxt  = RUN;
            end else if (if_stall_req) begin
                state_nxt = DRAIN;
            end else begin
                state_nxt = RUN;
            end
        end
    end

    assign jump_flag = pc_redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            pend_addr <= '0;
        end else begin
            state     <= state_nxt;
            pend_addr <= pend_addr_nxt;
        end
    end

    // The pipeline is already flushed while draining, so EX cannot legally request a jump.
    assert property (@(posedge clk) disable iff (rst) !(state == DRAIN && ex_jump_req));

    pipe_ctrl_perf_cnt #(.W(CNT_W), .SAT(1'b1)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .en  (|stall_state),
        .cnt (stall_cycles)
    );

    pipe_ctrl_perf_cnt #(.W(CNT_W), .SAT(1'b0)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .en  (pc_redirect),
        .cnt (flush_count)
    );

endmodule
